cpu_stats_counter: RTL and testbench

Execution-statistics and display-mode unit for the single-cycle MIPS core. It counts retired instructions, unconditional jumps and taken conditional branches. It freezes all counts when the program halts. It also debounces the board's mode button into the 2-bit page select used by the seven-segment display driver. All outputs are registered and feed the display driver's `totaltimes`, `JMP`, `CJMP` and `mode` inputs directly.

---
 rtl/cpu_stats_counter.sv | 134 +++++++++++++
 tb/tb_cpu_stats_counter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_stats_counter.sv
// cpu_stats_counter
//   Execution statistics and display-mode unit for the single-cycle MIPS core.
//   It counts retired instructions, unconditional jumps and taken conditional
//   branches, and freezes the counts once the halting syscall retires. It also
//   debounces the board's mode button into the 2-bit display page select.
//   All outputs are registered.
//
// Ports
//   clk          : system clock, all state changes on the rising edge
//   rst_n        : asynchronous active-low reset
//   retire       : one-cycle strobe, one instruction completed this cycle
//   is_jmp       : retiring instruction is j/jal/jr (qualified by retire)
//   is_branch    : retiring instruction is beq/bne (qualified by retire)
//   branch_taken : branch condition true (qualified by retire & is_branch)
//   halt         : retiring instruction is the halting syscall
//   clr          : synchronous clear of counters and halted flag
//   btn_mode     : raw, bouncing, active-high push-button
//   totaltimes   : retired-instruction count (saturating)
//   JMP          : unconditional-jump count (saturating)
//   CJMP         : taken-conditional-branch count (saturating)
//   mode         : display page 0 LED data, 1 total, 2 JMP/CJMP, 3 memory
//   halted       : program has halted, counters frozen
module cpu_stats_counter #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        retire,
  input  logic        is_jmp,
  input  logic        is_branch,
  input  logic        branch_taken,
  input  logic        halt,
  input  logic        clr,
  input  logic        btn_mode,
  output logic [15:0] totaltimes,
  output logic [15:0] JMP,
  output logic [15:0] CJMP,
  output logic [1:0]  mode,
  output logic        halted
);

  // The debounce counter never exceeds DEBOUNCE_CYCLES-1.
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] SAT = 16'hFFFF;

  logic [15:0]      total_q, total_d;
  logic [15:0]      jmp_q, jmp_d;
  logic [15:0]      cjmp_q, cjmp_d;
  logic             halted_q, halted_d;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             rise_q, rise_d;
  logic [1:0]       mode_q, mode_d;

  // Statistics counters. clr wins over a same-cycle retirement, and once
  // halted nothing but clr or reset can change the counts. Each counter
  // evaluates its own condition, so an illegal jmp+branch still counts both.
  always_comb begin
    total_d  = total_q;
    jmp_d    = jmp_q;
    cjmp_d   = cjmp_q;
    halted_d = halted_q;
    if (clr) begin
      total_d  = '0;
      jmp_d    = '0;
      cjmp_d   = '0;
      halted_d = 1'b0;
    end else if (retire && !halted_q) begin
      if (total_q != SAT) total_d = total_q + 16'd1;
      if (is_jmp && jmp_q != SAT) jmp_d = jmp_q + 16'd1;
      if (is_branch && branch_taken && cjmp_q != SAT) cjmp_d = cjmp_q + 16'd1;
      if (halt) halted_d = 1'b1;
    end
  end

  // Button path: two-flop synchronizer, then a counter that must see the
  // synchronized level differ from the stable level for DEBOUNCE_CYCLES
  // consecutive cycles before accepting it. Any return to the stable level
  // restarts the window. A registered rising-edge flag steps mode one cycle
  // after the stable level goes high; releases are ignored.
  always_comb begin
    sync1_d  = btn_mode;
    sync2_d  = sync1_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    rise_d = stable_d & ~stable_q;
    mode_d = rise_q ? mode_q + 2'd1 : mode_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_q  <= '0;
      jmp_q    <= '0;
      cjmp_q   <= '0;
      halted_q <= 1'b0;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      mode_q   <= '0;
    end else begin
      total_q  <= total_d;
      jmp_q    <= jmp_d;
      cjmp_q   <= cjmp_d;
      halted_q <= halted_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      mode_q   <= mode_d;
    end
  end

  assign totaltimes = total_q;
  assign JMP        = jmp_q;
  assign CJMP       = cjmp_q;
  assign mode       = mode_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_cpu_stats_counter.sv
// tb_cpu_stats_counter
//   Self-checking bench for cpu_stats_counter with DEBOUNCE_CYCLES = 4.
//   A behavioural model tracks the expected counts, halted flag and display
//   mode; every cycle all outputs are compared against it, and directed
//   scenarios add fixed expected values on top.
module tb_cpu_stats_counter;

  localparam int DC = 4;

  logic        clk;
  logic        rst_n;
  logic        retire, is_jmp, is_branch, branch_taken, halt, clr, btn_mode;
  logic [15:0] totaltimes, jmp_cnt, cjmp_cnt;
  logic [1:0]  mode;
  logic        halted;

  int checks = 0;
  int failures = 0;

  // Model state
  int m_total, m_jmp, m_cjmp;
  bit m_halted;
  bit m_stable;
  bit m_rise_pending;
  int m_mode;
  bit btn_hist[$];

  cpu_stats_counter #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .retire       (retire),
    .is_jmp       (is_jmp),
    .is_branch    (is_branch),
    .branch_taken (branch_taken),
    .halt         (halt),
    .clr          (clr),
    .btn_mode     (btn_mode),
    .totaltimes   (totaltimes),
    .JMP          (jmp_cnt),
    .CJMP         (cjmp_cnt),
    .mode         (mode),
    .halted       (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, observed, expected);
    end
  endtask

  function automatic void modelReset();
    m_total = 0;
    m_jmp = 0;
    m_cjmp = 0;
    m_halted = 1'b0;
    m_stable = 1'b0;
    m_rise_pending = 1'b0;
    m_mode = 0;
    btn_hist.delete();
  endfunction

  // Button level sampled k edges before the latest one; 0 before reset release.
  function automatic bit pastBtn(int k);
    int idx;
    idx = btn_hist.size() - 1 - k;
    return (idx >= 0) ? btn_hist[idx] : 1'b0;
  endfunction

  // Apply the rules of one clock edge to the model.
  function automatic void modelEdge(bit r, bit j, bit br, bit tk, bit h, bit c, bit b);
    bit all_diff;
    if (c) begin
      m_total = 0;
      m_jmp = 0;
      m_cjmp = 0;
      m_halted = 1'b0;
    end else if (r && !m_halted) begin
      m_total = (m_total < 65535) ? m_total + 1 : 65535;
      if (j) m_jmp = (m_jmp < 65535) ? m_jmp + 1 : 65535;
      if (br && tk) m_cjmp = (m_cjmp < 65535) ? m_cjmp + 1 : 65535;
      if (h) m_halted = 1'b1;
    end
    // Button: the synchronized level lags the pin by two edges; it is accepted
    // once the last DC synchronized samples all disagree with the stable level.
    btn_hist.push_back(b);
    if (m_rise_pending) m_mode = (m_mode + 1) % 4;
    m_rise_pending = 1'b0;
    all_diff = 1'b1;
    for (int k = 2; k <= DC + 1; k++)
      if (pastBtn(k) == m_stable) all_diff = 1'b0;
    if (all_diff) begin
      m_stable = ~m_stable;
      if (m_stable) m_rise_pending = 1'b1;
    end
    if (btn_hist.size() > 32) void'(btn_hist.pop_front());
  endfunction

  // Drive one cycle of inputs, advance a clock edge, then compare everything.
  task automatic applyStimulus(input bit r, input bit j, input bit br, input bit tk,
                               input bit h, input bit c, input bit b);
    retire = r;
    is_jmp = j;
    is_branch = br;
    branch_taken = tk;
    halt = h;
    clr = c;
    btn_mode = b;
    @(posedge clk);
    modelEdge(r, j, br, tk, h, c, b);
    #1;
    checkOutput("totaltimes", 32'(totaltimes), 32'(m_total));
    checkOutput("JMP", 32'(jmp_cnt), 32'(m_jmp));
    checkOutput("CJMP", 32'(cjmp_cnt), 32'(m_cjmp));
    checkOutput("halted", 32'(halted), 32'(m_halted));
    checkOutput("mode", 32'(mode), 32'(m_mode));
  endtask

  task automatic idle(input int n, input bit b);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, b);
  endtask

  task automatic pressButton(input int hold);
    for (int i = 0; i < hold; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1);
    idle(8, 0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_total"}, 32'(totaltimes), 0);
    checkOutput({tag, "_jmp"}, 32'(jmp_cnt), 0);
    checkOutput({tag, "_cjmp"}, 32'(cjmp_cnt), 0);
    checkOutput({tag, "_mode"}, 32'(mode), 0);
    checkOutput({tag, "_halted"}, 32'(halted), 0);
  endtask

  initial begin
    // Reset with random inputs
    rst_n = 1'b0;
    retire = 1'($urandom);
    is_jmp = 1'($urandom);
    is_branch = 1'($urandom);
    branch_taken = 1'($urandom);
    halt = 1'($urandom);
    clr = 1'($urandom);
    btn_mode = 1'($urandom);
    modelReset();
    #12;
    checkAllZero("reset");
    retire = 0; is_jmp = 0; is_branch = 0; branch_taken = 0;
    halt = 0; clr = 0; btn_mode = 0;
    rst_n = 1'b1;

    // Five retires: jumps on 2 and 4, taken branch on 5
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 1, 1, 0, 0, 0);
    checkOutput("five_total", 32'(totaltimes), 5);
    checkOutput("five_jmp", 32'(jmp_cnt), 2);
    checkOutput("five_cjmp", 32'(cjmp_cnt), 1);

    // Ten back-to-back not-taken branches
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) applyStimulus(1, 0, 1, 0, 0, 0, 0);
    checkOutput("nt_total", 32'(totaltimes), 16'h000A);
    checkOutput("nt_cjmp", 32'(cjmp_cnt), 0);

    // Halt freezes counting; clr with a retire clears and does not count it
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 0, 0);
    checkOutput("halt_set", 32'(halted), 1);
    checkOutput("halt_total", 32'(totaltimes), 4);
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 1, 1, 0, 0, 0);
    checkOutput("frozen_total", 32'(totaltimes), 4);
    checkOutput("frozen_jmp", 32'(jmp_cnt), 0);
    applyStimulus(1, 1, 0, 0, 0, 1, 0);
    checkOutput("clr_total", 32'(totaltimes), 0);
    checkOutput("clr_jmp", 32'(jmp_cnt), 0);
    checkOutput("clr_halted", 32'(halted), 0);

    // Debounce: a short glitch is rejected
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    idle(10, 0);
    checkOutput("glitch_mode", 32'(mode), 0);

    // A 10-cycle press steps mode exactly 7 edges after onset
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      if (i == 6) checkOutput("press_edge6", 32'(mode), 0);
      if (i == 7) checkOutput("press_edge7", 32'(mode), 1);
    end
    idle(10, 0);
    checkOutput("release_mode", 32'(mode), 1);
    pressButton(8);
    checkOutput("press2_mode", 32'(mode), 2);
    pressButton(8);
    checkOutput("press3_mode", 32'(mode), 3);
    pressButton(8);
    checkOutput("press4_mode", 32'(mode), 0);

    // Randomized mixed traffic, including bouncing button activity
    begin
      bit b;
      b = 1'b0;
      for (int i = 0; i < 600; i++) begin
        bit r, j, br, tk, h, c;
        if ($urandom_range(7) == 0) b = ~b;
        r  = ($urandom_range(3) != 0);
        j  = ($urandom_range(3) == 0);
        br = ($urandom_range(2) == 0);
        tk = 1'($urandom);
        h  = ($urandom_range(59) == 0);
        c  = ($urandom_range(39) == 0);
        applyStimulus(r, j, br, tk, h, c, b);
      end
      idle(10, 0);
    end

    // Bring mode to 2 with nonzero counters, then reset between edges
    for (int i = 0; i < 4 && m_mode != 2; i++) pressButton(8);
    checkOutput("pre_reset_mode", 32'(mode), 2);
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 1, 1, 0, 0, 0);
    checkOutput("pre_reset_total", 32'(totaltimes), 2);
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("async_reset");
    modelReset();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    checkOutput("post_reset_total", 32'(totaltimes), 1);

    // Saturation at 16'hFFFF
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 65535; i++) applyStimulus(1, 1, 0, 0, 0, 0, 0);
    checkOutput("sat_total", 32'(totaltimes), 32'hFFFF);
    checkOutput("sat_jmp", 32'(jmp_cnt), 32'hFFFF);
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 0, 0, 0, 0);
    checkOutput("sat_hold_total", 32'(totaltimes), 32'hFFFF);
    checkOutput("sat_hold_jmp", 32'(jmp_cnt), 32'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
